// File: rtl/weight_control_if.sv
// weight_control_if: load-sensor/clear inputs and overload flag/counter outputs of the overload detector
interface weight_control_if #(
  parameter int CNT_W = 8
);
  logic             weight_flip;
  logic             weight_flip_reset;
  logic             weight_limit_exceeded;
  logic [CNT_W-1:0] overload_events;
  modport master (
    output weight_flip,
    output weight_flip_reset,
    input  weight_limit_exceeded,
    input  overload_events
  );
  modport slave (
    input  weight_flip,
    input  weight_flip_reset,
    output weight_limit_exceeded,
    output overload_events
  );
endinterface

// File: rtl/weight_control.sv
// weight_control: synchronized overload detector with sticky flag and saturating event counter; optional debounce via WEIGHT_CONTROL_DEBOUNCE_EN
module weight_control #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input logic             clk,
  input logic             reset,
  weight_control_if.slave bus
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("weight_control: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
    $error("weight_control: DEBOUNCE_CYCLES must be 1..255");
  end
  logic [SYNC_STAGES-1:0] wf_sync_q, wr_sync_q;
  logic                   wf_s, wr_s, wf_f, wf_prev_q, ovl_evt;
  logic                   flag_q, flag_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  // two independent synchronizer chains for the asynchronous switch and clear
  always_ff @(posedge clk) begin
    if (reset) begin
      wf_sync_q <= '0;
      wr_sync_q <= '0;
    end else begin
      wf_sync_q <= {wf_sync_q[SYNC_STAGES-2:0], bus.weight_flip};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], bus.weight_flip_reset};
    end
  end
  assign wf_s = wf_sync_q[SYNC_STAGES-1];
  assign wr_s = wr_sync_q[SYNC_STAGES-1];
`ifdef WEIGHT_CONTROL_DEBOUNCE_EN
  logic       wf_f_q, wf_f_d, db_hit;
  logic [7:0] db_cnt_q, db_cnt_d;
  // count consecutive disagreements; adopt wf_s once the window has filled
  always_comb begin
    db_hit   = (wf_s != wf_f_q) && (db_cnt_q == 8'(DEBOUNCE_CYCLES - 1));
    wf_f_d   = db_hit ? wf_s : wf_f_q;
    db_cnt_d = (wf_s == wf_f_q || db_hit) ? 8'd0 : db_cnt_q + 8'd1;
  end
  // debounce state; reset drops any partial window
  always_ff @(posedge clk) begin
    if (reset) begin
      wf_f_q   <= 1'b0;
      db_cnt_q <= 8'd0;
    end else begin
      wf_f_q   <= wf_f_d;
      db_cnt_q <= db_cnt_d;
    end
  end
  assign wf_f = wf_f_q;
`else
  assign wf_f = wf_s;
`endif
  assign ovl_evt = wf_f & ~wf_prev_q;
  // event sets the flag and wins over a simultaneous clear; counter saturates
  always_comb begin
    flag_d = ovl_evt ? 1'b1 : (wr_s ? 1'b0 : flag_q);
    cnt_d  = (ovl_evt && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // edge-detect history and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wf_prev_q <= 1'b0;
      flag_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wf_prev_q <= wf_f;
      flag_q    <= flag_d;
      cnt_q     <= cnt_d;
    end
  end
  assign bus.weight_limit_exceeded = flag_q;
  assign bus.overload_events       = cnt_q;
endmodule

// File: tb/tb_weight_control.sv
// tb_weight_control: directed and random stimulus checked against a sample-history reference model
module tb_weight_control;
  localparam int S    = 2;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   h [0:S];
  bit   r [0:S];
  logic m_flag;
  int   m_cnt;
  weight_control_if #(.CNT_W(CW)) bus ();
  weight_control #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(4), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic f, input int c);
    check({tag, "_flag"}, {31'd0, bus.weight_limit_exceeded}, {31'd0, f});
    check({tag, "_count"}, {24'd0, bus.overload_events}, c);
  endtask
  // one clock: drive inputs, update the model from the samples seen, compare at the falling edge
  task automatic cyc(input bit wf, input bit wr, input bit rs);
    bit ev;
    bus.weight_flip = wf;
    bus.weight_flip_reset = wr;
    reset = rs;
    @(posedge clk);
    if (rs) begin
      h = '{default: 1'b0};
      r = '{default: 1'b0};
      m_flag = 1'b0;
      m_cnt = 0;
    end else begin
      ev = h[S-1] & ~h[S];
      if (ev) begin
        m_flag = 1'b1;
        if (m_cnt < MAXC) m_cnt++;
      end else if (r[S-1]) m_flag = 1'b0;
      for (int k = S; k > 0; k--) begin
        h[k] = h[k-1];
        r[k] = r[k-1];
      end
      h[0] = wf;
      r[0] = wr;
    end
    @(negedge clk);
`ifndef WEIGHT_CONTROL_DEBOUNCE_EN
    check("model_flag", {31'd0, bus.weight_limit_exceeded}, {31'd0, m_flag});
    check("model_count", {24'd0, bus.overload_events}, m_cnt);
`endif
  endtask
  initial begin
    bus.weight_flip = 1'b0;
    bus.weight_flip_reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    expect_out("reset", 1'b0, 0);
`ifdef WEIGHT_CONTROL_DEBOUNCE_EN
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0);
    expect_out("glitch", 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0);
      if (i == 5) expect_out("db_edge6", 1'b0, 0);
      if (i == 6) expect_out("db_edge7", 1'b1, 1);
    end
    for (int i = 0; i < 12; i++) cyc(0, 0, 0);
    expect_out("db_end", 1'b1, 1);
`else
    for (int i = 0; i < 2; i++) cyc(0, 0, 0);
    expect_out("idle", 1'b0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    expect_out("rise_edge2", 1'b0, 0);
    cyc(1, 0, 0);
    expect_out("rise_edge3", 1'b1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    expect_out("sticky", 1'b1, 1);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    expect_out("clr_edge2", 1'b1, 1);
    cyc(0, 0, 0);
    expect_out("clr_edge3", 1'b0, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1);
    for (int i = 0; i < 200; i++) cyc(bit'((i / 5) % 2), bit'(i % 10 == 7 || i % 10 == 8), 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0);
    expect_out("toggle", 1'b0, 20);
    for (int i = 0; i < 300; i++) begin
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    expect_out("saturate", 1'b1, 255);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    expect_out("evt_clr_same", 1'b1, 1);
    cyc(1, 1, 0);
    expect_out("evt_clr_next", 1'b0, 1);
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1);
      expect_out("held_reset", 1'b0, 0);
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    expect_out("held_release", 1'b1, 1);
    begin
      bit wf = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) wf = ~wf;
        cyc(wf, bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 99) == 0));
      end
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
